// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a per-register busy scoreboard that raises a decode hazard on pending destinations.
module reg_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_stall,
    input  logic        ll_issue,
    input  logic [4:0]  ll_issue_addr,
    input  logic        ll_valid,
    input  logic [4:0]  ll_addr,
    input  logic [31:0] ll_data,
    output logic        ll_ready,
    input  logic [4:0]  rd1_addr,
    input  logic [4:0]  rd2_addr,
    input  logic [4:0]  dst_addr,
    output logic        hazard,
    output logic        we,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    logic [4:0]    mem_addr [DEPTH];
    logic [31:0]   mem_data [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] starve_cnt;
    logic [31:0]   busy;

    logic          fifo_empty;
    logic          fifo_full;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;
    logic          pipe_req;
    logic          starved;
    logic          pop;
    logic          bypass;
    logic          push;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          clr_en;
    logic [4:0]    clr_addr;
    logic [AW:0]   count_next;
    logic [CW-1:0] starve_next;
    logic [31:0]   busy_next;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == STARVE_MAX) ? v : v + 1'b1;
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign head_addr  = mem_addr[rd_ptr];
    assign head_data  = mem_data[rd_ptr];
    assign pipe_req   = pipe_we && (pipe_waddr != 5'd0);
    assign starved    = (starve_cnt == STARVE_MAX) && !fifo_empty;

    // Grant: a starved FIFO beats the pipeline, the pipeline beats a waiting FIFO,
    // and an incoming result skips the empty FIFO only when nobody else wants the port.
    always_comb begin
        pop      = 1'b0;
        bypass   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'd0;
        clr_en   = 1'b0;
        clr_addr = 5'd0;
        if (starved || (!pipe_req && !fifo_empty)) begin
            pop      = 1'b1;
            wr_en    = (head_addr != 5'd0);
            wr_addr  = head_addr;
            wr_data  = head_data;
            clr_en   = (head_addr != 5'd0);
            clr_addr = head_addr;
        end else if (pipe_req) begin
            wr_en    = 1'b1;
            wr_addr  = pipe_waddr;
            wr_data  = pipe_wdata;
        end else if (ll_valid) begin
            bypass   = 1'b1;
            wr_en    = (ll_addr != 5'd0);
            wr_addr  = ll_addr;
            wr_data  = ll_data;
            clr_en   = (ll_addr != 5'd0);
            clr_addr = ll_addr;
        end
    end

    // Full is judged on the registered count, so a pop cannot reopen ll_ready in the same cycle.
    assign push = ll_valid && !fifo_full && !bypass;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // The counter measures how long the oldest pending result has been waiting since the last pop.
    always_comb begin
        starve_next = '0;
        if (!pop && (count_next != '0)) begin
            starve_next = sat_inc(starve_cnt);
        end
    end

    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_addr] = 1'b0;
        end
        if (ll_issue && (ll_issue_addr != 5'd0)) begin
            busy_next[ll_issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            busy       <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            count      <= count_next;
            starve_cnt <= starve_next;
            busy       <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= ll_addr;
            mem_data[wr_ptr] <= ll_data;
        end
    end

    assign we         = rst && wr_en;
    assign write_addr = rst ? wr_addr : 5'd0;
    assign write_data = rst ? wr_data : 32'd0;
    assign ll_ready   = rst && !fifo_full;
    assign pipe_stall = rst && starved;
    assign hazard     = rst && (busy[rd1_addr] || busy[rd2_addr] || busy[dst_addr]);

endmodule
